// File: rtl/spi_word_target.sv
// SPI target with configurable word width, mode and bit order. Every pin is synchronised into
// sys_clk, and edges are detected there; SPI clock is never used as a clock.
module spi_word_target #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter bit                    CPOL        = 1'b0,
    parameter bit                    CPHA        = 1'b0,
    parameter bit                    MSB_FIRST   = 1'b1,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE     = '1
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset_n,
    input  logic                  spi_cs_n,
    input  logic                  spi_sclk,
    input  logic                  spi_rx,
    output logic                  spi_tx,
    output logic                  spi_tx_oe,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  frame_abort
);

    localparam int unsigned    CntW    = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, rx_sync_q;
    logic                   cs_hist_q, sclk_hist_q;
    logic                   cs_s, sclk_s, rx_s;
    logic                   cs_fall, cs_rise, lead_edge, trail_edge, sample_edge, shift_edge;

    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  skip_q, skip_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;

    logic do_load, first_load, do_sample, do_shift, word_done;

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            rx_sync_q   <= '0;
            cs_hist_q   <= 1'b1;
            sclk_hist_q <= CPOL;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            rx_sync_q   <= {rx_sync_q[SYNC_STAGES-2:0], spi_rx};
            cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign rx_s   = rx_sync_q[SYNC_STAGES-1];

    assign cs_fall     = cs_hist_q & ~cs_s;
    assign cs_rise     = ~cs_hist_q & cs_s;
    // Edges are judged on the CPOL-normalised clock so that leading always means 0->1.
    assign lead_edge   = (sclk_s ^ CPOL) & ~(sclk_hist_q ^ CPOL);
    assign trail_edge  = ~(sclk_s ^ CPOL) & (sclk_hist_q ^ CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    // State register
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cs_fall) state_d = StActive;
            StActive: if (cs_rise) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output / control decode; CS rise wins over any sclk edge in the same cycle
    always_comb begin
        frame_start = 1'b0;
        frame_end   = 1'b0;
        frame_abort = 1'b0;
        do_load     = 1'b0;
        first_load  = 1'b0;
        do_sample   = 1'b0;
        do_shift    = 1'b0;
        word_done   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    frame_start = 1'b1;
                    do_load     = 1'b1;
                    first_load  = 1'b1;
                end
            end
            StActive: begin
                if (cs_rise) begin
                    frame_end   = 1'b1;
                    frame_abort = (bit_cnt_q != '0);
                end else if (sample_edge) begin
                    do_sample = 1'b1;
                    if (bit_cnt_q == LastBit) begin
                        word_done = 1'b1;
                        do_load   = 1'b1;
                    end
                end else if (shift_edge) begin
                    do_shift = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign tx_ready    = do_load;
    assign tx_underrun = do_load & ~tx_valid;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        skip_d     = skip_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        if (frame_start || frame_end) begin
            bit_cnt_d = '0;
            skip_d    = 1'b0;
        end
        if (do_sample) begin
            rx_sh_d   = MSB_FIRST ? {rx_sh_q[DATA_WIDTH-2:0], rx_s}
                                  : {rx_s, rx_sh_q[DATA_WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + CntW'(1);
        end
        if (word_done) begin
            bit_cnt_d  = '0;
            rx_data_d  = rx_sh_d;
            rx_valid_d = 1'b1;
        end
        if (do_shift) begin
            if (skip_q) begin
                skip_d = 1'b0;
            end else begin
                tx_sh_d = MSB_FIRST ? {tx_sh_q[DATA_WIDTH-2:0], 1'b1}
                                    : {1'b1, tx_sh_q[DATA_WIDTH-1:1]};
            end
        end
        if (do_load) begin
            tx_sh_d = tx_valid ? tx_data : TX_IDLE;
            // With CPHA=0 the first trailing edge of a frame must already advance to bit 1.
            skip_d  = first_load ? CPHA : 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            bit_cnt_q  <= '0;
            skip_q     <= 1'b0;
            tx_sh_q    <= TX_IDLE;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            skip_q     <= skip_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign spi_tx    = MSB_FIRST ? tx_sh_q[DATA_WIDTH-1] : tx_sh_q[0];
    assign spi_tx_oe = ~cs_s;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;

endmodule
